mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the fetch stage (IF) and the load/store stage (MEM).
- Drives the select of the 32-bit 2:1 address/data muxes in front of the RAM: sel=0 routes IF, sel=1 routes MEM.
- Sequences each access with a fixed-latency wait and returns read data to the winning requester.
- Sits between the pipeline stages and the RAM model.

Parameters:
- MEM_LATENCY, 1, cycles from the RAM issue cycle (ram_en high) to ram_rdata being valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request (level); held with if_addr stable until if_valid.
- if_addr  in  32  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch access issued.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- mem_req  in  1  load/store request (level); held with address/data stable until mem_valid.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_gnt  out  1  one-cycle pulse: data access issued.
- mem_valid  out  1  one-cycle pulse: load data valid, or store complete.
- mem_rdata  out  32  load data.
- sel  out  1  mux select (0 = IF, 1 = MEM); holds its value between accesses.
- ram_en  out  1  one-cycle access strobe.
- ram_we  out  1  write enable; qualified by ram_en.
- ram_addr  out  32  registered address to the RAM.
- ram_wdata  out  32  registered write data.
- ram_rdata  in  32  RAM read data.

Behaviour:
- Reset values: all outputs 0 (sel=0, rdata buses 0, all pulses low), state IDLE, latency counter 0, last_winner=MEM.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Any request: choose a winner, latch its address, write data and we into ram_* registers, set sel=winner, go to ISSUE.
- ISSUE (1 cycle):
  - ram_en=1 and the winner's gnt=1.
  - Counter loads MEM_LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, sample ram_rdata into the winner's rdata register (loads only; stores leave rdata unchanged) and go to RESP.
- RESP (1 cycle):
  - Winner's valid=1; update last_winner; return to IDLE.
  - Requests are ignored in RESP, so a req still high at this edge is not serviced twice.
- Timing: req sampled at edge k → gnt/ram_en high in cycle k+1 → valid high in cycle k+2+MEM_LATENCY. Access period is MEM_LATENCY+3 cycles.
- Default winner rule: fixed priority, MEM over IF. A data stall is more costly than a fetch stall.
- A request dropped before grant is simply not serviced. Dropping req after grant does not abort the access.
- rdata outputs hold their last value until the next completion.
- Reset mid-access (ISSUE/WAIT/RESP): the transaction is discarded; no valid is issued; reset values apply on the next cycle.
- Non-winning requests stay pending; they are arbitrated again at the next IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, grant the requester that was not last_winner. A lone request is always granted. With last_winner reset to MEM, IF is served first after reset.
- Undefined: fixed MEM>IF priority. last_winner is not implemented.

Decomposition:
- Shared package riscv_arb_pkg holds:
  - State encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Requester IDs: SEL_IF=1'b0, SEL_MEM=1'b1.
  - LAT_W = 4 (counter width).
- One natural sub-module, arb_lat_counter: load, decrement and zero-flag for the WAIT state.

Test Plan:
All scenarios use MEM_LATENCY=2.
- Reset held 2 cycles with both requests high → every output 0, sel=0, no gnt during or in the cycle after reset.
- IF alone, if_addr=0x10, RAM returns 0xDEADBEEF → if_gnt with ram_en=1, ram_addr=0x10, sel=0 in cycle k+1; if_valid with if_rdata=0xDEADBEEF in cycle k+4; single pulses only.
- Both requesting in the same cycle (default build): MEM store, addr 0x20, wdata 0x12345678, plus IF read 0x24 → MEM granted first (sel=1, ram_we=1, ram_wdata=0x12345678, mem_valid at k+4, mem_rdata unchanged); IF gnt at k+6.
- ARB_ROUND_ROBIN_EN defined, both requests held high across 4 accesses → grant order IF, MEM, IF, MEM; each access is 5 cycles long.
- Reset asserted during WAIT of an IF read → no if_valid, outputs zeroed; a new IF request at 0x40 afterwards completes normally with correct data.
- if_req held high through the RESP cycle, then dropped → exactly one if_gnt and one if_valid.

Source files
------------

// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg: shared state encodings, requester ids and counter width for the memory port arbiter
package riscv_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_MEM = 1'b1;
  localparam int LAT_W = 4;
endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: loadable latency down-counter with zero flag
import riscv_arb_pkg::*;
module arb_lat_counter (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] init,
  output logic             zero
);
  logic [LAT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= init;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between IF and MEM; ARB_ROUND_ROBIN_EN swaps MEM>IF priority for round-robin
import riscv_arb_pkg::*;
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  state_t state, state_d;
  logic win, zero, start;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner;
  assign win = (if_req && mem_req) ? ~last_winner : mem_req;
  always_ff @(posedge clk)
    if (reset) last_winner <= SEL_MEM;
    else if (state == RESP) last_winner <= sel;
`else
  assign win = mem_req ? SEL_MEM : SEL_IF;
`endif
  assign start = state == IDLE && (if_req || mem_req);
  always_comb begin
    state_d = state == IDLE  ? (start ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (zero ? RESP : WAIT) : IDLE;
  end
  arb_lat_counter u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (state == ISSUE),
    .dec  (state == WAIT && !zero),
    .init (LAT_W'(MEM_LATENCY - 1)),
    .zero (zero)
  );
  assign ram_en    = state == ISSUE;
  assign if_gnt    = ram_en && sel == SEL_IF;
  assign mem_gnt   = ram_en && sel == SEL_MEM;
  assign if_valid  = state == RESP && sel == SEL_IF;
  assign mem_valid = state == RESP && sel == SEL_MEM;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= SEL_IF;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_d;
      if (start) begin
        sel       <= win;
        ram_we    <= win && mem_we;
        ram_addr  <= win ? mem_addr : if_addr;
        ram_wdata <= win ? mem_wdata : '0;
      end
      // stores complete without touching the load data register
      if (state == WAIT && zero && !ram_we) begin
        if (sel) mem_rdata <= ram_rdata;
        else if_rdata <= ram_rdata;
      end
    end
  end
endmodule
